// File: rtl/game_timing_pkg.sv
// game_timing_pkg: shared state encoding and defaults
// for the game-tick round timer.
package game_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  localparam int TPS_DEF   = 40;
  localparam int RSECS_DEF = 60;
  localparam int OVR_W     = 8;

  // Tens digit of a 0..99 constant, by comparison only.
  function automatic logic [3:0] bcd_tens(
    input int v
  );
    logic [3:0] t;
    t = '0;
    for (int i = 1; i < 10; i++) begin
      if (v >= i * 10) t = 4'(i);
    end
    return t;
  endfunction

  // Ones digit of a 0..99 constant.
  function automatic logic [3:0] bcd_ones(
    input int v
  );
    int t;
    t = int'(bcd_tens(v));
    return 4'(v - 10 * t);
  endfunction

endpackage

// File: rtl/bcd2_down_counter.sv
// bcd2_down_counter: two-digit loadable BCD
// down counter, holds at 00.
module bcd2_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);

  assign zero = (tens == 4'd0) &&
                (ones == 4'd0);

  // Load wins; decrement borrows ones 0->9 from tens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (dec && !zero) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_tick_timer.sv
// game_tick_timer: turns the game tick strobe into
// round timekeeping and a per-tick step handshake.
module game_tick_timer
  import game_timing_pkg::*;
#(
  parameter int TICKS_PER_SEC = TPS_DEF,
  parameter int ROUND_SECS    = RSECS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  output logic             step_req,
  input  logic             step_ack,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic [6:0]       secs_left,
  output logic [3:0]       secs_tens,
  output logic [3:0]       secs_ones,
  output logic             running,
  output logic             time_up
);

  localparam logic [7:0] SUB_LAST =
    8'(TICKS_PER_SEC - 1);
  localparam logic [6:0] SECS_LOAD =
    7'(ROUND_SECS);
  localparam logic [3:0] LOAD_T =
    bcd_tens(ROUND_SECS);
  localparam logic [3:0] LOAD_O =
    bcd_ones(ROUND_SECS);

  state_t     state;
  logic [7:0] sub_cnt;
  logic       accept;
  logic       wrap;
  logic       last;
  logic       go_pause;
  logic       go_resume;
  logic       bcd_zero;
  logic       bcd_dec;

  // start overrides everything, so the FSM
  // branches below are mutually exclusive.
  assign accept = (state == RUN) && tick &&
                  !pause && !start;
  assign wrap   = accept &&
                  (sub_cnt == SUB_LAST);
  assign last   = wrap &&
                  (secs_left == 7'd1);
  assign go_pause  = !start &&
                     (state == RUN) && pause;
  assign go_resume = !start &&
                     (state == PAUSED) && !pause;
  assign bcd_dec   = wrap && !bcd_zero;

  // Round FSM with sub-tick and binary seconds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      running   <= 1'b0;
      time_up   <= 1'b0;
      sub_cnt   <= 8'd0;
      secs_left <= 7'd0;
    end else begin
      time_up <= 1'b0;
      unique case (1'b1)
        start: begin
          state     <= RUN;
          running   <= 1'b1;
          sub_cnt   <= 8'd0;
          secs_left <= SECS_LOAD;
        end
        go_pause: begin
          state   <= PAUSED;
          running <= 1'b0;
        end
        go_resume: begin
          state   <= RUN;
          running <= 1'b1;
        end
        accept: begin
          if (wrap) begin
            sub_cnt   <= 8'd0;
            secs_left <= secs_left - 7'd1;
          end else begin
            sub_cnt <= sub_cnt + 8'd1;
          end
          if (last) begin
            state   <= DONE;
            running <= 1'b0;
            time_up <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Step request per accepted tick; unconsumed
  // requests at the next tick count as overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_req    <= 1'b0;
      overrun_cnt <= '0;
    end else if (start) begin
      step_req    <= 1'b0;
      overrun_cnt <= '0;
    end else if (accept) begin
      step_req <= 1'b1;
      if (step_req && !step_ack &&
          (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end else if (step_req && step_ack) begin
      step_req <= 1'b0;
    end
  end

  bcd2_down_counter u_secs_bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .load_tens (LOAD_T),
    .load_ones (LOAD_O),
    .dec       (bcd_dec),
    .tens      (secs_tens),
    .ones      (secs_ones),
    .zero      (bcd_zero)
  );

endmodule

// File: tb/tb_game_tick_timer.sv
// tb_game_tick_timer: directed stimulus with a
// queued scoreboard for game_tick_timer.
module tb_game_tick_timer;

  localparam int TPS = 4;
  localparam int RS  = 70;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       step_ack = 1'b0;
  logic       step_req;
  logic [7:0] overrun_cnt;
  logic [6:0] secs_left;
  logic [3:0] secs_tens;
  logic [3:0] secs_ones;
  logic       running;
  logic       time_up;

  game_tick_timer #(
    .TICKS_PER_SEC (TPS),
    .ROUND_SECS    (RS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .start       (start),
    .pause       (pause),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .overrun_cnt (overrun_cnt),
    .secs_left   (secs_left),
    .secs_tens   (secs_tens),
    .secs_ones   (secs_ones),
    .running     (running),
    .time_up     (time_up)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         cyc;
    bit         async;
    logic [6:0] secs;
    logic       req;
    logic [7:0] ovr;
    logic       run;
    logic       tup;
  } exp_t;

  exp_t q[$];
  exp_t ea;
  exp_t eb;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;

  logic [6:0] e_secs;
  logic       e_req;
  logic [7:0] e_ovr;
  logic       e_run;
  logic       e_tup;

  task automatic push(input string nm,
                      input bit as);
    exp_t e;
    e.nm    = nm;
    e.cyc   = cyc_n + 1;
    e.async = as;
    e.secs  = e_secs;
    e.req   = e_req;
    e.ovr   = e_ovr;
    e.run   = e_run;
    e.tup   = e_tup;
    q.push_back(e);
  endtask

  task automatic go(input logic t, input logic s,
                    input logic p, input logic a,
                    input string nm);
    @(negedge clk);
    tick     = t;
    start    = s;
    pause    = p;
    step_ack = a;
    push(nm, 1'b0);
  endtask

  task automatic compare(input exp_t e);
    logic [3:0] et;
    logic [3:0] eo;
    et = 4'(e.secs / 10);
    eo = 4'(e.secs % 10);
    checks++;
    if ({secs_left, secs_tens, secs_ones,
         step_req, overrun_cnt, running,
         time_up} !==
        {e.secs, et, eo, e.req, e.ovr,
         e.run, e.tup}) begin
      errors++;
      $display({"FAIL %s cyc %0d: got secs=%0d ",
                "bcd=%0d%0d req=%b ovr=%0d run=%b ",
                "tup=%b, want secs=%0d bcd=%0d%0d ",
                "req=%b ovr=%0d run=%b tup=%b"},
               e.nm, cyc_n, secs_left, secs_tens,
               secs_ones, step_req, overrun_cnt,
               running, time_up, e.secs, et, eo,
               e.req, e.ovr, e.run, e.tup);
    end
  endtask

  // Clocked monitor: pops entries due this cycle.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    while (q.size() > 0 && !q[0].async &&
           q[0].cyc <= cyc_n) begin
      ea = q.pop_front();
      compare(ea);
    end
  end

  // Reset monitor: checks outputs just after an
  // asynchronous reset assertion.
  always @(negedge rst_n) begin
    #1;
    if (q.size() > 0 && q[0].async) begin
      eb = q.pop_front();
      compare(eb);
    end
  end

  initial begin
    e_secs = '0;
    e_req  = 1'b0;
    e_ovr  = '0;
    e_run  = 1'b0;
    e_tup  = 1'b0;

    go(0, 0, 0, 0, "reset");
    go(1, 1, 0, 0, "reset_in");
    go(0, 0, 0, 0, "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    go(1, 0, 0, 0, "idle_tick");

    e_secs = 7'(RS);
    e_run  = 1'b1;
    go(0, 1, 0, 0, "start");
    for (int k = 1; k <= RS * TPS; k++) begin
      e_secs = 7'(RS - k / TPS);
      e_req  = 1'b1;
      e_tup  = (k == RS * TPS);
      e_run  = !e_tup;
      go(1, 0, 0, 0, "round_tick");
      e_tup = 1'b0;
      go(0, 0, 0, 0, "round_hold");
      e_req = 1'b0;
      go(0, 0, 0, 1, "round_ack");
      go(0, 0, 0, 0, "round_idle");
    end
    go(1, 0, 0, 0, "done_tick");
    go(0, 0, 0, 1, "done_ack");

    e_secs = 7'(RS);
    e_run  = 1'b1;
    go(0, 1, 0, 0, "restart_done");
    for (int k = 1; k <= 5; k++) begin
      e_secs = 7'(RS - k / TPS);
      e_req  = 1'b1;
      e_ovr  = 8'(k - 1);
      go(1, 0, 0, 0, "ovr_tick");
    end
    e_secs = 7'(RS - 6 / TPS);
    go(1, 0, 0, 1, "tick_with_ack");
    for (int k = 7; k <= 270; k++) begin
      e_secs = 7'(RS - k / TPS);
      e_ovr  = (k - 2 > 255) ? 8'd255
                             : 8'(k - 2);
      go(1, 0, 0, 0, "ovr_sat");
    end
    go(0, 0, 0, 0, "ovr_hold");

    e_secs = 7'(RS);
    e_req  = 1'b0;
    e_ovr  = 8'd0;
    go(0, 1, 0, 0, "restart_run");
    e_req = 1'b1;
    go(1, 0, 0, 0, "p_tick1");
    e_req = 1'b0;
    go(0, 0, 0, 1, "p_ack");
    e_run = 1'b0;
    go(1, 0, 1, 0, "pause_edge_tick");
    for (int i = 0; i < 20; i++) begin
      go(1, 0, 1, 0, "paused_tick");
      go(0, 0, 1, 0, "paused_gap");
    end
    e_run = 1'b1;
    go(0, 0, 0, 0, "resume");
    e_req = 1'b1;
    go(1, 0, 0, 0, "r_tick2");
    e_ovr = 8'd1;
    go(1, 0, 0, 0, "r_tick3");
    e_ovr  = 8'd2;
    e_secs = 7'(RS - 1);
    go(1, 0, 0, 0, "r_tick4");
    go(0, 0, 0, 0, "r_hold");

    @(posedge clk);
    #2;
    e_secs = '0;
    e_req  = 1'b0;
    e_ovr  = '0;
    e_run  = 1'b0;
    push("async_rst", 1'b1);
    rst_n = 1'b0;
    go(1, 0, 0, 0, "in_reset");
    go(0, 1, 0, 0, "start_in_reset");
    go(0, 0, 0, 0, "in_reset2");
    @(negedge clk);
    rst_n = 1'b1;
    go(1, 0, 0, 0, "post_rst_tick");
    e_secs = 7'(RS);
    e_run  = 1'b1;
    go(1, 1, 0, 0, "start_with_tick");
    e_req = 1'b1;
    go(1, 0, 0, 0, "first_tick");
    go(0, 0, 0, 0, "end_hold");

    for (int i = 0; i < 50 && q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending %0d, want 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/game_tick_timer.md
# game_tick_timer

Consumer end of the game-tick strobe: takes the one-cycle tick pulse produced by the tick generator (one pulse every 2,499,500 clocks at 100 MHz, ≈40 Hz) and turns it into round timekeeping plus a per-tick game-step handshake. It counts ticks into seconds, counts a round down from a loaded value, and issues one step request per accepted tick to the game logic. It also detects steps the game logic failed to consume before the next tick. Sits between the tick generator and the game state/rendering logic.

## Interface
- TICKS_PER_SEC, 40, accepted ticks per displayed second; legal range 2..255
- ROUND_SECS, 60, round length in seconds; legal range 1..99
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle strobe from the tick generator
- start  in  1  pulse; (re)starts a round from any state
- pause  in  1  level; while high in RUN the timer freezes
- step_req  out  1  game-step request; held until acknowledged
- step_ack  in  1  game logic consumed the step
- overrun_cnt  out  8  ticks that arrived while step_req was pending without ack; saturates at 255
- secs_left  out  7  binary seconds remaining
- secs_tens  out  4  BCD tens digit of secs_left
- secs_ones  out  4  BCD ones digit of secs_left
- running  out  1  high in RUN only
- time_up  out  1  one-cycle pulse when secs_left reaches 0

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset → IDLE.
- Any state, start=1: secs_left←ROUND_SECS, BCD←digits of ROUND_SECS, sub-tick counter←0, step_req←0, overrun_cnt←0, go RUN. start has priority over tick, pause and step_ack that cycle.
- RUN, pause=1 → PAUSED (a tick in that cycle is dropped). PAUSED, pause=0 → RUN.
- RUN, tick=1, pause=0: accepted tick.
  - Sub-tick counter increments; at TICKS_PER_SEC-1 it wraps to 0 and secs_left decrements by 1; BCD digits decrement in step (ones 0→9 borrows from tens).
  - If secs_left was 1 on that wrap: secs_left←0, time_up pulses, → DONE.
  - Step handshake: if step_req=0, or step_req=1 with step_ack=1 the same cycle, step_req←1. If step_req=1 and step_ack=0, step_req stays 1 and overrun_cnt increments (saturating).
- step_ack=1 with step_req=1 and no accepted tick: step_req←0. step_ack with step_req=0 is ignored.
- Ticks in IDLE, PAUSED, DONE are ignored entirely (no counting, no request, no overrun).
- DONE: a pending step_req stays until acked; no new requests. Only start leaves DONE.
- BCD is maintained as counters, never by division.

## Timing
- All outputs registered. Reset values: step_req 0, overrun_cnt 0, secs_left 0, secs_tens 0, secs_ones 0, running 0, time_up 0.
- Accepted tick in cycle n → step_req, secs_left/BCD, time_up updated at n+1.
- start in cycle n → running=1, secs_left=ROUND_SECS at n+1.
- Ack in cycle n → step_req low at n+1.
- Back-to-back ticks in adjacent cycles are each handled; no tick is merged.
- rst_n low at any time: immediate return to IDLE with all outputs at reset values, independent of clk.

## Structure
- Shared package game_timing_pkg: state enum (IDLE/RUN/PAUSED/DONE), default TICKS_PER_SEC=40 and ROUND_SECS=60 constants, overrun counter width.
- One sub-module: bcd2_down_counter (two-digit loadable BCD down counter with decrement enable and zero flag), instantiated for the seconds display.
- Top holds the FSM, sub-tick counter, binary secs_left and the step handshake.

## Test plan
- TICKS_PER_SEC=4, ROUND_SECS=3; start, then 12 ticks spaced 10 cycles, each acked after 2 cycles → secs_left 3→2→1→0 after ticks 4/8/12, time_up exactly one cycle after tick 12, state DONE, overrun_cnt=0.
- ROUND_SECS=10; start, 4 ticks (one second) → secs_tens=0, secs_ones=9, secs_left=9.
- Run, never ack; 5 ticks → step_req=1 throughout, overrun_cnt=4. Repeat with 300 ticks → overrun_cnt=255.
- Tick and step_ack in the same cycle while step_req=1 → step_req stays 1, overrun_cnt unchanged.
- pause high for 20 ticks → secs_left, sub-counter and step_req unchanged; a tick coincident with the pause rising edge is dropped; resume continues from frozen count.
- Mid-round rst_n asserted asynchronously between clock edges → all outputs 0 immediately; after release, ticks ignored until start; start coincident with a tick → secs_left=ROUND_SECS, step_req=0.
